// File: rtl/n_piso_serializer.sv
// Parallel-in, serial-out serializer with valid/ready load and selectable bit order.
// Define N_PISO_PARITY_EN to append an even-parity bit to every frame.
module n_piso_serializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dir,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_data,
    input  logic         flush,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         ser_last,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
`ifdef N_PISO_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(N);
`else
    localparam logic [CW-1:0] LAST = CW'(N - 1);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [N-1:0]  sreg, sreg_d;
    logic          dir_q, dir_d;
    logic          out_d, valid_d, last_d;
    logic          at_last, accept;
`ifdef N_PISO_PARITY_EN
    logic          par_q, par_d;
`endif

    assign at_last    = (state == SHIFT) && (cnt == LAST);
    assign load_ready = (state == IDLE) || (at_last && !flush);
    assign accept     = load_valid && load_ready;
    assign busy       = (state != IDLE);

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sreg_d  = sreg;
        dir_d   = dir_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
`ifdef N_PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (state == SHIFT && flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            // The first bit goes straight to the output register; sreg keeps the rest.
            state_d = SHIFT;
            cnt_d   = '0;
            dir_d   = dir;
            valid_d = 1'b1;
            out_d   = dir ? load_data[0] : load_data[N-1];
            sreg_d  = dir ? (load_data >> 1) : (load_data << 1);
`ifdef N_PISO_PARITY_EN
            par_d   = ^load_data;
`endif
        end else if (state == SHIFT) begin
            if (at_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt + 1'b1;
                valid_d = 1'b1;
                last_d  = (cnt_d == LAST);
                out_d   = dir_q ? sreg[0] : sreg[N-1];
                sreg_d  = dir_q ? (sreg >> 1) : (sreg << 1);
`ifdef N_PISO_PARITY_EN
                if (cnt == CW'(N - 1)) out_d = par_q;
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            dir_q     <= 1'b0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
`ifdef N_PISO_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sreg      <= sreg_d;
            dir_q     <= dir_d;
            ser_out   <= out_d;
            ser_valid <= valid_d;
            ser_last  <= last_d;
`ifdef N_PISO_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_n_piso_serializer.sv
// Self-checking bench for n_piso_serializer: directed cases plus random traffic
// against a queue-of-bits frame model and a paired receiver shift register.
module tb_n_piso_serializer;

    localparam int N = 8;
`ifdef N_PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dir, load_valid, load_ready, flush;
    logic [N-1:0] load_data;
    logic         ser_out, ser_valid, ser_last, busy;

    n_piso_serializer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .dir(dir), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .flush(flush),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bits still to be presented for the current frame, front = on the line now.
    bit           fbits[$];
    int           fidx;
    logic [N-1:0] fword;
    logic         fdir;
    logic [N-1:0] rx;
    logic [31:0]  cap;
    int           vcount;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ser_valid"}, ser_valid, 0);
        check({tag, "_ser_out"}, ser_out, 0);
        check({tag, "_ser_last"}, ser_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_load_ready"}, load_ready, 1);
    endtask

    // One clock cycle: drive inputs at the falling edge, check, then advance the model at the rising edge.
    task automatic step(input logic lv, input logic [N-1:0] d, input logic dr, input logic fl);
        int   sz;
        logic exp_out, ready_exp;
        load_valid = lv;
        load_data  = d;
        dir        = dr;
        flush      = fl;
        #1;
        sz      = fbits.size();
        exp_out = 1'b0;
        if (sz > 0) exp_out = fbits[0];
        ready_exp = (sz == 0) || (sz == 1 && !fl);
        check("ser_valid", ser_valid, sz > 0);
        check("ser_out", ser_out, exp_out);
        check("ser_last", ser_last, sz == 1);
        check("busy", busy, sz > 0);
        check("load_ready", load_ready, ready_exp);
        if (ser_valid) begin
            cap = {cap[30:0], ser_out};
            vcount++;
            if (sz > 0 && fidx < N) begin
                rx = fdir ? {ser_out, rx[N-1:1]} : {rx[N-2:0], ser_out};
                if (fidx == N - 1) check("rx_word", rx, fword);
            end
        end
        @(posedge clk);
        if (sz > 0 && fl) begin
            fbits.delete();
        end else begin
            if (sz > 0) begin
                void'(fbits.pop_front());
                fidx++;
            end
            if (lv && ready_exp) begin
                for (int i = 0; i < N; i++) fbits.push_back(dr ? d[i] : d[N-1-i]);
                if (PAR == 1) fbits.push_back(^d);
                fidx  = 0;
                fword = d;
                fdir  = dr;
                rx    = '0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; dir = 1'b0; load_valid = 1'b0; flush = 1'b0; load_data = '0;
        fidx = 0; fword = '0; fdir = 1'b0; rx = '0; cap = '0; vcount = 0;
        #1;
        check_idle_outputs("in_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, '0, 1'b0, 1'b0);

        // MSB first
        cap = '0; vcount = 0;
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        repeat (N + PAR + 1) step(1'b0, $urandom, 1'b0, 1'b0);
        check("a5_msb_beats", vcount, N + PAR);
        check("a5_msb_seq", cap[N+PAR-1:PAR], 8'hA5);

        // LSB first, dir toggled throughout the frame
        cap = '0; vcount = 0;
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < N + PAR + 1; i++) step(1'b0, $urandom, i[0], 1'b0);
        check("a5_lsb_seq", cap[N+PAR-1:PAR], 8'hA5);

        // Back-to-back frames with load_valid held high
        cap = '0; vcount = 0;
        step(1'b1, 8'h0F, 1'b0, 1'b0);
        repeat (N + PAR) step(1'b1, 8'hF0, 1'b0, 1'b0);
        repeat (N + PAR + 1) step(1'b0, '0, 1'b0, 1'b0);
        check("b2b_beats", vcount, 2 * (N + PAR));
`ifndef N_PISO_PARITY_EN
        check("b2b_seq", cap[15:0], 16'h0FF0);
`endif

        // Flush on bit 3 together with a load, then a fresh frame
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1);
        check("flush_drop_valid", ser_valid, 0);
        cap = '0; vcount = 0;
        step(1'b1, 8'h66, 1'b1, 1'b0);
        repeat (N + PAR + 1) step(1'b0, '0, 1'b0, 1'b0);
        check("after_flush_beats", vcount, N + PAR);

        // Flush while idle must not block a load
        step(1'b1, 8'h81, 1'b0, 1'b1);
        repeat (N + PAR + 1) step(1'b0, '0, 1'b0, 1'b0);

`ifdef N_PISO_PARITY_EN
        cap = '0; vcount = 0;
        step(1'b1, 8'h07, 1'b0, 1'b0);
        repeat (N + PAR + 1) step(1'b0, '0, 1'b0, 1'b0);
        check("par_beats", vcount, 9);
        check("par_seq", cap[8:0], 9'h00F);
`endif

        // Reset in the middle of a frame clears outputs at once
        step(1'b1, 8'h07, 1'b0, 1'b0);
        repeat (5) step(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        fbits.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0);
        repeat (N + PAR + 1) step(1'b0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
